// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - received-byte stream between PS/2 frame sequencer and scan-code decoder
interface ps2_rx_if;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;

   modport master (output rd_data, output rd_valid, input rd_ready);
   modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/ps2_rx_sequencer.sv
// rtl/ps2_rx_sequencer.sv - PS/2 device-to-host frame receiver with error pulses and byte FIFO
module ps2_rx_sequencer #(
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic     clk,
   input  logic     resetn,
   input  logic     ps2_clk_db,
   input  logic     ps2_data_db,
   ps2_rx_if.master rd,
   output logic     rx_busy,
   output logic     parity_err,
   output logic     frame_err,
   output logic     timeout_err,
   output logic     overrun_err
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic [1:0]    state, state_next;
   logic          prev_clk;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          parity_bit;
   logic [TW-1:0] to_cnt;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic fall, to_hit, fall_ok, stop_eval, par_ok, good, pop, push_ok;

   assign fall      = prev_clk & ~ps2_clk_db;
   assign to_hit    = (state != S_IDLE) && (to_cnt == TO_LAST);
   // A fall coinciding with the timeout is discarded along with the partial frame.
   assign fall_ok   = fall & ~to_hit;
   assign stop_eval = fall_ok && (state == S_STOP);
   assign par_ok    = ^{shift_reg, parity_bit};
   assign good      = stop_eval & par_ok & ps2_data_db;

   assign rd.rd_valid = (count != '0);
   assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : 8'h00;
   assign pop         = rd.rd_valid & rd.rd_ready;
   assign push_ok     = good && ((count != FULL_CNT) || pop);

   always_comb begin
      state_next = state;
      if (to_hit) begin
         state_next = S_IDLE;
      end else if (fall) begin
         case (state)
            S_IDLE:   if (!ps2_data_db) state_next = S_DATA;
            S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
            S_PARITY: state_next = S_STOP;
            default:  state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= S_IDLE;
         prev_clk    <= 1'b1;
         bit_cnt     <= 3'd0;
         shift_reg   <= 8'h00;
         parity_bit  <= 1'b0;
         to_cnt      <= '0;
         rx_busy     <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else begin
         prev_clk    <= ps2_clk_db;
         state       <= state_next;
         rx_busy     <= (state_next != S_IDLE);
         parity_err  <= stop_eval & ~par_ok;
         frame_err   <= stop_eval & par_ok & ~ps2_data_db;
         timeout_err <= to_hit;
         overrun_err <= good & ~push_ok;

         if ((state == S_IDLE) || fall || to_hit)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + TW'(1);

         if (fall_ok) begin
            case (state)
               S_IDLE:   bit_cnt <= 3'd0;
               S_DATA: begin
                  shift_reg <= {ps2_data_db, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
               S_PARITY: parity_bit <= ps2_data_db;
               default:  ;
            endcase
         end

         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && push_ok) mem[wr_ptr] <= shift_reg;
   end
endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// tb/tb_ps2_rx_sequencer.sv - directed bench for ps2_rx_sequencer
module tb_ps2_rx_sequencer;
   localparam int T    = 64;
   localparam int HALF = 8;

   logic clk = 1'b0;
   logic resetn, ps2_clk_db, ps2_data_db;
   logic rx_busy, parity_err, frame_err, timeout_err, overrun_err;
   ps2_rx_if rif();

   ps2_rx_sequencer #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .ps2_clk_db(ps2_clk_db), .ps2_data_db(ps2_data_db),
      .rd(rif), .rx_busy(rx_busy), .parity_err(parity_err), .frame_err(frame_err),
      .timeout_err(timeout_err), .overrun_err(overrun_err));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int n_par = 0, n_frm = 0, n_to = 0, n_ovr = 0, cyc = 0, t_fall = 0;
   logic [7:0] got[$];
   logic       snap_valid, snap2_valid, snap_busy, snap_perr, snap_ferr, snap_ovr;
   logic [7:0] snap_data;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      if (parity_err === 1'b1)  n_par++;
      if (frame_err === 1'b1)   n_frm++;
      if (timeout_err === 1'b1) n_to++;
      if (overrun_err === 1'b1) n_ovr++;
      if (rif.rd_valid === 1'b1 && rif.rd_ready === 1'b1) got.push_back(rif.rd_data);
   end

   function automatic logic [10:0] mkframe(input logic [7:0] d, input bit bad_par, input logic stop);
      logic p;
      p = ~^d;
      if (bad_par) p = ~p;
      return {stop, p, d, 1'b0};
   endfunction

   // One PS/2 bit; snapshots outputs right after the posedge that sees the fall.
   task automatic ps2_bit(input logic b, input bit pr);
      @(negedge clk); ps2_data_db = b;
      repeat (HALF-1) @(negedge clk);
      ps2_clk_db = 1'b0;
      if (pr) rif.rd_ready = 1'b1;
      @(posedge clk); #1;
      snap_valid = rif.rd_valid; snap_data = rif.rd_data; snap_busy = rx_busy;
      snap_perr = parity_err; snap_ferr = frame_err; snap_ovr = overrun_err; t_fall = cyc;
      @(negedge clk);
      if (pr) rif.rd_ready = 1'b0;
      @(posedge clk); #1;
      snap2_valid = rif.rd_valid;
      repeat (HALF-1) @(negedge clk);
      ps2_clk_db = 1'b1;
   endtask

   task automatic send_frame(input logic [10:0] f, input int n, input bit pr_last);
      for (int i = 0; i < n; i++) ps2_bit(f[i], pr_last && (i == n-1));
   endtask

   task automatic test_reset;
      resetn = 1'b0; ps2_clk_db = 1'b1; ps2_data_db = 1'b1; rif.rd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (rif.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b want 0", rif.rd_valid); end
      vectors++; if (rif.rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data got %h want 00", rif.rd_data); end
      vectors++; if ({rx_busy, parity_err, frame_err, timeout_err, overrun_err} !== 5'b0) begin
         miscompares++; $display("FAIL reset_flags got %b want 00000", {rx_busy, parity_err, frame_err, timeout_err, overrun_err}); end
      @(negedge clk); resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      int g0, e0;
      g0 = got.size(); e0 = n_par + n_frm + n_to + n_ovr;
      rif.rd_ready = 1'b1;
      send_frame(mkframe(8'h1C, 0, 1'b1), 11, 0);
      vectors++; if (snap_valid !== 1'b1 || snap_data !== 8'h1C) begin miscompares++;
         $display("FAIL basic_latency got valid=%b data=%h want 1/1c", snap_valid, snap_data); end
      vectors++; if (snap2_valid !== 1'b0) begin miscompares++; $display("FAIL basic_one_cycle got %b want 0", snap2_valid); end
      vectors++; if (got.size() != g0 + 1 || got[got.size()-1] !== 8'h1C) begin miscompares++;
         $display("FAIL basic_popped got n=%0d want n=%0d", got.size(), g0 + 1); end
      vectors++; if (n_par + n_frm + n_to + n_ovr != e0) begin miscompares++;
         $display("FAIL basic_no_err got %0d want %0d", n_par + n_frm + n_to + n_ovr, e0); end
   endtask

   task automatic test_parity;
      int g0, p0, f0;
      g0 = got.size(); p0 = n_par; f0 = n_frm;
      send_frame(mkframe(8'hF0, 1, 1'b1), 11, 0);
      vectors++; if (snap_perr !== 1'b1 || snap_ferr !== 1'b0) begin miscompares++;
         $display("FAIL parity_pulse got perr=%b ferr=%b want 1/0", snap_perr, snap_ferr); end
      vectors++; if (snap_valid !== 1'b0 || got.size() != g0) begin miscompares++;
         $display("FAIL parity_dropped got valid=%b n=%0d want 0/%0d", snap_valid, got.size(), g0); end
      vectors++; if (n_par - p0 != 1 || n_frm != f0) begin miscompares++;
         $display("FAIL parity_count got %0d/%0d want 1/0", n_par - p0, n_frm - f0); end
   endtask

   task automatic test_framing;
      int g0, f0, p0;
      g0 = got.size(); f0 = n_frm; p0 = n_par;
      send_frame(mkframe(8'h5A, 0, 1'b0), 11, 0);
      vectors++; if (snap_ferr !== 1'b1 || snap_perr !== 1'b0 || snap_valid !== 1'b0) begin miscompares++;
         $display("FAIL frame_pulse got ferr=%b perr=%b valid=%b want 1/0/0", snap_ferr, snap_perr, snap_valid); end
      vectors++; if (n_frm - f0 != 1 || n_par != p0 || got.size() != g0) begin miscompares++;
         $display("FAIL frame_count got %0d n=%0d want 1 n=%0d", n_frm - f0, got.size(), g0); end
      send_frame(mkframe(8'h29, 0, 1'b1), 11, 0);
      vectors++; if (snap_valid !== 1'b1 || snap_data !== 8'h29) begin miscompares++;
         $display("FAIL frame_next got valid=%b data=%h want 1/29", snap_valid, snap_data); end
   endtask

   task automatic test_timeout;
      int k, t0;
      t0 = n_to; k = 0;
      send_frame(11'b000_0000_1010, 4, 0);
      vectors++; if (snap_busy !== 1'b1) begin miscompares++; $display("FAIL timeout_busy_before got %b want 1", snap_busy); end
      while (timeout_err !== 1'b1 && k < 4*T) begin @(posedge clk); #1; k++; end
      vectors++; if (cyc - t_fall != T) begin miscompares++;
         $display("FAIL timeout_delay got %0d cycles want %0d", cyc - t_fall, T); end
      vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy_after got %b want 0", rx_busy); end
      @(posedge clk); #1;
      vectors++; if (timeout_err !== 1'b0 || n_to - t0 != 1) begin miscompares++;
         $display("FAIL timeout_single got %b count=%0d want 0 count=1", timeout_err, n_to - t0); end
      send_frame(mkframe(8'h12, 0, 1'b1), 11, 0);
      vectors++; if (snap_valid !== 1'b1 || snap_data !== 8'h12) begin miscompares++;
         $display("FAIL timeout_next got valid=%b data=%h want 1/12", snap_valid, snap_data); end
   endtask

   task automatic test_overrun;
      int g0, o0;
      logic [7:0] exp_q [5];
      exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04; exp_q[4] = 8'h06;
      g0 = got.size(); o0 = n_ovr;
      rif.rd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send_frame(mkframe(8'(i), 0, 1'b1), 11, 0);
         if (i == 4) begin
            vectors++; if (snap_ovr !== 1'b0 || snap_data !== 8'h01) begin miscompares++;
               $display("FAIL overrun_fill got ovr=%b head=%h want 0/01", snap_ovr, snap_data); end
         end
      end
      vectors++; if (snap_ovr !== 1'b1 || n_ovr - o0 != 1) begin miscompares++;
         $display("FAIL overrun_fifth got ovr=%b count=%0d want 1/1", snap_ovr, n_ovr - o0); end
      send_frame(mkframe(8'h06, 0, 1'b1), 11, 1);
      vectors++; if (snap_ovr !== 1'b0 || n_ovr - o0 != 1) begin miscompares++;
         $display("FAIL overrun_push_pop got ovr=%b count=%0d want 0/1", snap_ovr, n_ovr - o0); end
      rif.rd_ready = 1'b1;
      repeat (8) @(negedge clk);
      vectors++; if (got.size() != g0 + 5) begin miscompares++;
         $display("FAIL overrun_drain_n got %0d want %0d", got.size() - g0, 5); end
      for (int i = 0; i < 5; i++) begin
         vectors++; if (got.size() <= g0 + i || got[g0+i] !== exp_q[i]) begin miscompares++;
            $display("FAIL overrun_order idx=%0d got %h want %h", i, (got.size() > g0 + i) ? got[g0+i] : 8'hxx, exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid;
      rif.rd_ready = 1'b0;
      send_frame(mkframe(8'h33, 0, 1'b1), 11, 0);
      send_frame(11'b000_0000_0010, 3, 0);
      vectors++; if (snap_busy !== 1'b1 || rif.rd_valid !== 1'b1) begin miscompares++;
         $display("FAIL midreset_pre got busy=%b valid=%b want 1/1", snap_busy, rif.rd_valid); end
      @(negedge clk); resetn = 1'b0;
      @(posedge clk); #1;
      vectors++; if (rif.rd_valid !== 1'b0 || rif.rd_data !== 8'h00 || rx_busy !== 1'b0) begin miscompares++;
         $display("FAIL midreset_out got valid=%b data=%h busy=%b want 0/00/0", rif.rd_valid, rif.rd_data, rx_busy); end
      vectors++; if ({parity_err, frame_err, timeout_err, overrun_err} !== 4'b0) begin miscompares++;
         $display("FAIL midreset_err got %b want 0000", {parity_err, frame_err, timeout_err, overrun_err}); end
      @(negedge clk); resetn = 1'b1; rif.rd_ready = 1'b1;
      repeat (2) @(negedge clk);
      send_frame(mkframe(8'h76, 0, 1'b1), 11, 0);
      vectors++; if (snap_valid !== 1'b1 || snap_data !== 8'h76 || got[got.size()-1] !== 8'h76) begin miscompares++;
         $display("FAIL midreset_after got valid=%b data=%h want 1/76", snap_valid, snap_data); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_parity;
      test_framing;
      test_timeout;
      test_overrun;
      test_reset_mid;
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
